// File: rtl/led_mode_ctrl_if.sv
// led_mode_ctrl_if: board-side signal bundle of the LED mode controller.
//   sw    : slide switches (asynchronous to the clock)
//   btn   : push buttons, active-high (asynchronous to the clock)
//   led   : registered LED drive
//   mode  : registered current display mode (debug/test visibility)
// Modports:
//   master : the board/stimulus side; drives sw/btn, observes led/mode
//   slave  : the controller; consumes sw/btn, drives led/mode
interface led_mode_ctrl_if;
   logic [3:0] sw;
   logic [3:0] btn;
   logic [3:0] led;
   logic [1:0] mode;

   modport master (output sw, output btn, input led, input mode);
   modport slave  (input sw, input btn, output led, output mode);
endinterface

// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: debounced four-button LED controller.
// Buttons select one of four LED sources: live mirror (sw | buttons),
// binary counter, bouncing single-LED chase, and switch-gated blink.
//   btn[0] next mode, btn[1] previous mode, btn[2] run/pause,
//   btn[3] clear pattern state.
// Ports:
//   CLK100MHZ : system clock, the only clock domain
//   ck_rst    : asynchronous active-low reset
//   bus       : led_mode_ctrl_if.slave (sw, btn in; led, mode out)
// Parameters:
//   DB_CYCLES   : stable synchronised cycles needed to accept a button change
//   TICK_CYCLES : pattern step period in clock cycles
module led_mode_ctrl #(
   parameter int DB_CYCLES   = 1_000_000,
   parameter int TICK_CYCLES = 25_000_000
) (
   input  logic             CLK100MHZ,
   input  logic             ck_rst,
   led_mode_ctrl_if.slave   bus
);

   localparam int DB_W   = (DB_CYCLES   > 1) ? $clog2(DB_CYCLES)   : 1;
   localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

   typedef enum logic [1:0] {
      MIRROR = 2'd0,
      COUNT  = 2'd1,
      CHASE  = 2'd2,
      BLINK  = 2'd3
   } mode_t;

   // synchronisers
   logic [3:0] sw_m, sw_s;
   logic [3:0] btn_m, btn_s;

   // debounce
   logic [3:0]      db;
   logic [3:0]      db_d;
   logic [DB_W-1:0] db_cnt [4];
   logic [3:0]      press;

   // control
   mode_t             mode_r;
   mode_t             mode_nxt;
   logic              run;
   logic              clr;
   logic [TICK_W-1:0] presc;
   logic              tick;

   // pattern state
   logic [3:0] count;
   logic [3:0] pos;
   logic       dir_down;
   logic       phase;
   logic [3:0] led_r;

   // Bounce at the ends: the direction flips on the step that leaves an end.
   function automatic logic chase_dir(input logic [3:0] p, input logic d);
      if (p == 4'b1000)
         return 1'b1;
      else if (p == 4'b0001)
         return 1'b0;
      else
         return d;
   endfunction

   function automatic logic [3:0] chase_pos(input logic [3:0] p, input logic d);
      return chase_dir(p, d) ? (p >> 1) : (p << 1);
   endfunction

   always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
      if (!ck_rst) begin
         sw_m  <= '0;
         sw_s  <= '0;
         btn_m <= '0;
         btn_s <= '0;
      end else begin
         sw_m  <= bus.sw;
         sw_s  <= sw_m;
         btn_m <= bus.btn;
         btn_s <= btn_m;
      end
   end

   // A button is accepted after DB_CYCLES consecutive mismatching cycles;
   // any agreeing cycle restarts the count.
   always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
      if (!ck_rst) begin
         db   <= '0;
         db_d <= '0;
         for (int i = 0; i < 4; i++)
            db_cnt[i] <= '0;
      end else begin
         db_d <= db;
         for (int i = 0; i < 4; i++) begin
            if (btn_s[i] == db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db[i]     <= ~db[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   assign press = db & ~db_d;

   // Opposing next/prev presses in one cycle cancel out.
   always_comb begin
      mode_nxt = mode_r;
      if (press[0] && !press[1])
         mode_nxt = mode_t'(mode_r + 2'd1);
      else if (press[1] && !press[0])
         mode_nxt = mode_t'(mode_r - 2'd1);
   end

   assign clr  = press[3] || (mode_nxt != mode_r);
   assign tick = run && (presc == TICK_LAST);

   // Mode, run flag, prescaler, pattern registers and LED drive.
   // led is built from the pre-update pattern values, so a pattern change
   // on one edge reaches the pins on the next.
   always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
      if (!ck_rst) begin
         mode_r   <= MIRROR;
         run      <= 1'b1;
         presc    <= '0;
         count    <= '0;
         pos      <= 4'b0001;
         dir_down <= 1'b0;
         phase    <= 1'b0;
         led_r    <= '0;
      end else begin
         mode_r <= mode_nxt;
         if (press[2])
            run <= ~run;

         if (clr || presc == TICK_LAST)
            presc <= '0;
         else
            presc <= presc + TICK_W'(1);

         if (clr) begin
            count    <= '0;
            pos      <= 4'b0001;
            dir_down <= 1'b0;
            phase    <= 1'b0;
         end else if (tick) begin
            case (mode_r)
               COUNT:   count <= count + 4'd1;
               CHASE: begin
                  pos      <= chase_pos(pos, dir_down);
                  dir_down <= chase_dir(pos, dir_down);
               end
               BLINK:   phase <= ~phase;
               default: ;
            endcase
         end

         case (mode_r)
            MIRROR:  led_r <= sw_s | db;
            COUNT:   led_r <= count;
            CHASE:   led_r <= pos;
            BLINK:   led_r <= phase ? sw_s : 4'b0000;
            default: led_r <= '0;
         endcase
      end
   end

   assign bus.led  = led_r;
   assign bus.mode = mode_r;

endmodule
